// File: rtl/btb_assoc.sv
// Set-associative branch target buffer with per-entry saturating direction counters.
// IF looks up the fetch PC combinationally from registered state; EX writes back one
// resolved outcome per cycle. Replacement is lowest-invalid-way first, else round-robin.
// Ports:
//   clk, rst (sync, active-low)
//   lookup_pc -> hit, pred_taken, pred_target   (combinational lookup)
//   upd_en, upd_pc, upd_taken, upd_target       (update applied at next rising edge)
//   invalidate                                  (clear all valid bits, drops same-cycle update)
module btb_assoc #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned SETS     = 16,
    parameter int unsigned WAYS     = 2,
    parameter int unsigned CNT_BITS = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [XLEN-1:0] lookup_pc,
    output logic            hit,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            upd_en,
    input  logic [XLEN-1:0] upd_pc,
    input  logic            upd_taken,
    input  logic [XLEN-1:0] upd_target,
    input  logic            invalidate
);

    localparam int unsigned IDX_W = $clog2(SETS);
    localparam int unsigned WAY_W = (WAYS > 1) ? $clog2(WAYS) : 1;
    localparam int unsigned TAG_W = XLEN - IDX_W - 2;

    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
    localparam logic [CNT_BITS-1:0] CNT_WT  = CNT_BITS'(1) << (CNT_BITS - 1);
    localparam logic [CNT_BITS-1:0] CNT_WNT = CNT_WT - CNT_BITS'(1);

    // Entry storage
    logic                r_valid  [SETS][WAYS];
    logic [TAG_W-1:0]    r_tag    [SETS][WAYS];
    logic [XLEN-1:0]     r_target [SETS][WAYS];
    logic [CNT_BITS-1:0] r_cnt    [SETS][WAYS];
    logic [WAY_W-1:0]    r_rr     [SETS];

    logic [IDX_W-1:0] w_l_idx;
    logic [TAG_W-1:0] w_l_tag;
    logic [IDX_W-1:0] w_u_idx;
    logic [TAG_W-1:0] w_u_tag;
    logic             w_l_hit;
    logic [WAY_W-1:0] w_l_way;
    logic             w_u_hit;
    logic [WAY_W-1:0] w_u_way;
    logic             w_inv_found;
    logic [WAY_W-1:0] w_inv_way;
    logic [WAY_W-1:0] w_alloc_way;
    logic             w_unused_pc_lsb;

    // pc[1:0] never participates in index or tag
    assign w_unused_pc_lsb = ^{lookup_pc[1:0], upd_pc[1:0]};

    assign w_l_idx = lookup_pc[IDX_W+1:2];
    assign w_l_tag = lookup_pc[XLEN-1:IDX_W+2];
    assign w_u_idx = upd_pc[IDX_W+1:2];
    assign w_u_tag = upd_pc[XLEN-1:IDX_W+2];

    // Lookup tag match; first (lowest-index) matching way wins
    always_comb begin
        w_l_hit = 1'b0;
        w_l_way = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_l_hit && r_valid[w_l_idx][w] && (r_tag[w_l_idx][w] == w_l_tag)) begin
                w_l_hit = 1'b1;
                w_l_way = WAY_W'(w);
            end
        end
    end

    // Prediction outputs, forced to zero while reset is held
    always_comb begin
        hit         = rst && w_l_hit;
        pred_taken  = 1'b0;
        pred_target = '0;
        if (hit) begin
            pred_taken  = r_cnt[w_l_idx][w_l_way][CNT_BITS-1];
            pred_target = r_target[w_l_idx][w_l_way];
        end
    end

    // Update-side match and victim selection
    always_comb begin
        w_u_hit     = 1'b0;
        w_u_way     = '0;
        w_inv_found = 1'b0;
        w_inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (!w_u_hit && r_valid[w_u_idx][w] && (r_tag[w_u_idx][w] == w_u_tag)) begin
                w_u_hit = 1'b1;
                w_u_way = WAY_W'(w);
            end
            if (!w_inv_found && !r_valid[w_u_idx][w]) begin
                w_inv_found = 1'b1;
                w_inv_way   = WAY_W'(w);
            end
        end
        w_alloc_way = w_inv_found ? w_inv_way : r_rr[w_u_idx];
    end

    // State update: reset > invalidate > resolved-branch update
    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int s = 0; s < SETS; s++) begin
                r_rr[s] <= '0;
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                    r_cnt[s][w]   <= CNT_WNT;
                end
            end
        end else if (invalidate) begin
            for (int s = 0; s < SETS; s++) begin
                for (int w = 0; w < WAYS; w++) begin
                    r_valid[s][w] <= 1'b0;
                end
            end
        end else if (upd_en) begin
            if (w_u_hit) begin
                if (upd_taken) begin
                    if (r_cnt[w_u_idx][w_u_way] != CNT_MAX) begin
                        r_cnt[w_u_idx][w_u_way] <= r_cnt[w_u_idx][w_u_way] + CNT_BITS'(1);
                    end
                    r_target[w_u_idx][w_u_way] <= upd_target;
                end else if (r_cnt[w_u_idx][w_u_way] != '0) begin
                    r_cnt[w_u_idx][w_u_way] <= r_cnt[w_u_idx][w_u_way] - CNT_BITS'(1);
                end
            end else if (upd_taken) begin
                r_valid[w_u_idx][w_alloc_way]  <= 1'b1;
                r_tag[w_u_idx][w_alloc_way]    <= w_u_tag;
                r_target[w_u_idx][w_alloc_way] <= upd_target;
                r_cnt[w_u_idx][w_alloc_way]    <= CNT_WT;
                // Round-robin pointer moves only when a valid entry is evicted
                if (!w_inv_found) begin
                    r_rr[w_u_idx] <= (r_rr[w_u_idx] == WAY_W'(WAYS - 1)) ? '0
                                   : r_rr[w_u_idx] + WAY_W'(1);
                end
            end
        end
    end

endmodule
